// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-unit port among NUM_CH requesters.
//
// A two-state FSM (IDLE/BUSY) grants one channel at a time. The grant is
// locked until the memory unit answers (mu_ready) or a flush aborts it.
// Every completion is followed by one IDLE cycle. This gives each requester
// a cycle to drop its ch_valid before arbitration runs again.
//
// Optional feature: define MEM_ARBITER_RR_EN to select round-robin
// arbitration. Without it, arbitration is fixed priority and the highest
// index wins.
//
// Ports:
//   clk_in, rst_in (sync, active-low), rdy_in (low = global stall)
//   flush_in                    abort the grant if FLUSH_MASK[grant_id] = 1
//   ch_valid/ch_wr [NUM_CH]     per-channel request and write flag
//   ch_len   [3*NUM_CH]         per-channel {unsigned, size[1:0]}
//   ch_addr/ch_value [32*NUM_CH] per-channel address and write data
//   ch_ready [NUM_CH]           one-cycle completion pulse (one-hot or zero)
//   ch_result [32]              read data, zero unless ch_ready is set
//   mu_valid/mu_wr/mu_len/mu_addr/mu_value -> memory unit request
//   mu_result/mu_ready          <- memory unit response
//   busy, grant_id              FSM status and granted channel
module mem_arbiter #(
  parameter int                NUM_CH     = 3,
  parameter logic [NUM_CH-1:0] FLUSH_MASK = {NUM_CH{1'b1}},
  localparam int               GID_W      = $clog2(NUM_CH)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush_in,
  input  logic [NUM_CH-1:0]    ch_valid,
  input  logic [NUM_CH-1:0]    ch_wr,
  input  logic [3*NUM_CH-1:0]  ch_len,
  input  logic [32*NUM_CH-1:0] ch_addr,
  input  logic [32*NUM_CH-1:0] ch_value,
  output logic [NUM_CH-1:0]    ch_ready,
  output logic [31:0]          ch_result,
  output logic                 mu_valid,
  output logic                 mu_wr,
  output logic [2:0]           mu_len,
  output logic [31:0]          mu_addr,
  output logic [31:0]          mu_value,
  input  logic [31:0]          mu_result,
  input  logic                 mu_ready,
  output logic                 busy,
  output logic [GID_W-1:0]     grant_id
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_d, state_q;
  logic [GID_W-1:0] grant_id_d, grant_id_q;
  logic [GID_W-1:0] winner;
  logic             flush_hit;
  logic             done;

`ifdef MEM_ARBITER_RR_EN
  logic [GID_W-1:0] rr_ptr_d, rr_ptr_q;
  logic             found;

  // Search starts one past the last granted channel and wraps around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      for (int j = 0; j < NUM_CH; j++) begin
        if (!found && ch_valid[j] && (j == (int'(rr_ptr_q) + 1 + k) % NUM_CH)) begin
          winner = GID_W'(j);
          found  = 1'b1;
        end
      end
    end
  end
`else
  // Later iterations override earlier ones, so the highest index wins.
  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid[i]) winner = GID_W'(i);
    end
  end
`endif

  assign flush_hit = flush_in & FLUSH_MASK[grant_id_q];

  // A completion is blocked by a stall or by a pending reset. A flush of a
  // flushable channel also blocks it, even when mu_ready is high.
  assign done = (state_q == BUSY) & rdy_in & rst_in & mu_ready & ~flush_hit;

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
`ifdef MEM_ARBITER_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    if (rdy_in) begin
      case (state_q)
        IDLE: begin
          if (!flush_in && (|ch_valid)) begin
            state_d    = BUSY;
            grant_id_d = winner;
`ifdef MEM_ARBITER_RR_EN
            rr_ptr_d   = winner;
`endif
          end
        end
        BUSY: begin
          if (flush_hit || mu_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      grant_id_q <= '0;
`ifdef MEM_ARBITER_RR_EN
      rr_ptr_q   <= GID_W'(NUM_CH - 1);
`endif
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
`ifdef MEM_ARBITER_RR_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

  // The memory-unit request is steered from the locked grant. It stays zero in IDLE.
  always_comb begin
    mu_valid  = 1'b0;
    mu_wr     = 1'b0;
    mu_len    = '0;
    mu_addr   = '0;
    mu_value  = '0;
    ch_ready  = '0;
    ch_result = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        if (state_q == BUSY) begin
          mu_valid = 1'b1;
          mu_wr    = ch_wr[i];
          mu_len   = ch_len[3*i +: 3];
          mu_addr  = ch_addr[32*i +: 32];
          mu_value = ch_value[32*i +: 32];
        end
        ch_ready[i] = done;
      end
    end
    if (done) ch_result = mu_result;
  end

  assign busy     = (state_q == BUSY);
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter (NUM_CH = 3). Stimulus pushes each expected
// completion {ch_ready, ch_result} into a queue in the cycle it must appear.
// A monitor pops and compares on every falling edge. A second instance with
// FLUSH_MASK = 3'b011 shares the stimulus to cover the non-flushable case.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic         clk_in = 1'b0;
  logic         rst_in, rdy_in, flush_in;
  logic [2:0]   ch_valid, ch_wr;
  logic [8:0]   ch_len;
  logic [95:0]  ch_addr, ch_value;
  logic [31:0]  mu_result;
  logic         mu_ready;

  logic [2:0]   ch_ready, m_ch_ready;
  logic [31:0]  ch_result, m_ch_result;
  logic         mu_valid, mu_wr, m_mu_valid, m_mu_wr;
  logic [2:0]   mu_len, m_mu_len;
  logic [31:0]  mu_addr, mu_value, m_mu_addr, m_mu_value;
  logic         busy, m_busy;
  logic [1:0]   grant_id, m_grant_id;

  typedef struct packed {
    logic [2:0]  rdy;
    logic [31:0] res;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(.NUM_CH(3)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .ch_valid(ch_valid), .ch_wr(ch_wr), .ch_len(ch_len), .ch_addr(ch_addr),
    .ch_value(ch_value), .ch_ready(ch_ready), .ch_result(ch_result),
    .mu_valid(mu_valid), .mu_wr(mu_wr), .mu_len(mu_len), .mu_addr(mu_addr),
    .mu_value(mu_value), .mu_result(mu_result), .mu_ready(mu_ready),
    .busy(busy), .grant_id(grant_id)
  );

  mem_arbiter #(.NUM_CH(3), .FLUSH_MASK(3'b011)) u_dut_m (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .ch_valid(ch_valid), .ch_wr(ch_wr), .ch_len(ch_len), .ch_addr(ch_addr),
    .ch_value(ch_value), .ch_ready(m_ch_ready), .ch_result(m_ch_result),
    .mu_valid(m_mu_valid), .mu_wr(m_mu_wr), .mu_len(m_mu_len), .mu_addr(m_mu_addr),
    .mu_value(m_mu_value), .mu_result(mu_result), .mu_ready(mu_ready),
    .busy(m_busy), .grant_id(m_grant_id)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_ch(input int k, input logic wr, input logic [2:0] len,
                        input logic [31:0] addr, input logic [31:0] value);
    ch_wr[k]            = wr;
    ch_len[3*k +: 3]    = len;
    ch_addr[32*k +: 32] = addr;
    ch_value[32*k +: 32] = value;
  endtask

  task automatic expect_done(input logic [2:0] rdy, input logic [31:0] res);
    exp_t e;
    e.rdy = rdy;
    e.res = res;
    exp_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    ch_valid = '0; ch_wr = '0; ch_len = '0; ch_addr = '0; ch_value = '0;
    mu_result = '0; mu_ready = 1'b0;

    // Monitor: compare every output cycle against the scoreboard head
    fork
      forever begin
        exp_t e;
        @(negedge clk_in);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_ch_ready", 32'(ch_ready), 32'(e.rdy));
          chk("sb_ch_result", ch_result, e.res);
        end else begin
          chk("idle_ch_ready", 32'(ch_ready), 32'h0);
          chk("idle_ch_result", ch_result, 32'h0);
        end
      end
    join_none

    // Reset state
    step(); step();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mu_valid", 32'(mu_valid), 32'h0);
    chk("rst_grant_id", 32'(grant_id), 32'h0);
    chk("rst_mu_addr", mu_addr, 32'h0);
    rst_in = 1'b1;
    step();
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Single read on channel 0, mu_ready after 4 cycles, with a grant-lock probe
    set_ch(0, 1'b0, 3'b010, 32'h0000_0100, 32'h0);
    set_ch(2, 1'b1, 3'b110, 32'h0000_0900, 32'h9999_9999);
    ch_valid = 3'b001;
    step();
    chk("rd_busy", 32'(busy), 32'h1);
    chk("rd_mu_valid", 32'(mu_valid), 32'h1);
    chk("rd_mu_addr", mu_addr, 32'h0000_0100);
    chk("rd_mu_len", 32'(mu_len), 32'h2);
    chk("rd_mu_wr", 32'(mu_wr), 32'h0);
    chk("rd_grant", 32'(grant_id), 32'h0);
    ch_valid = 3'b101;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("lock_mu_addr", mu_addr, 32'h0000_0100);
      chk("lock_grant", 32'(grant_id), 32'h0);
    end
    mu_ready = 1'b1; mu_result = 32'hDEAD_BEEF;
    expect_done(3'b001, 32'hDEAD_BEEF);
    step();
    ch_valid = 3'b000; mu_ready = 1'b0;
    chk("rd_idle_after", 32'(busy), 32'h0);
    chk("rd_idle_mu_valid", 32'(mu_valid), 32'h0);
    step();

`ifdef MEM_ARBITER_RR_EN
    // Round-robin with all channels valid and an instant mu_ready.
    // The first grant after reset is 0.
    ch_valid = 3'b111; mu_ready = 1'b1; mu_result = 32'h0000_00AA;
    rst_in = 1'b0;
    step();
    rst_in = 1'b1;
    for (int n = 0; n < 4; n++) begin
      expect_done(3'b000, 32'h0);
      step();
      chk("rr_busy", 32'(busy), 32'h1);
      chk("rr_grant", 32'(grant_id), 32'(n % 3));
      expect_done(3'b001 << (n % 3), 32'h0000_00AA);
      step();
    end
    ch_valid = 3'b000; mu_ready = 1'b0;
    step();
`else
    // Fixed priority with channels 0 and 1 contending: 1 is served first, then 0
    set_ch(1, 1'b1, 3'b011, 32'h0000_0200, 32'h1111_1111);
    set_ch(0, 1'b0, 3'b001, 32'h0000_0300, 32'h0);
    ch_valid = 3'b011; mu_ready = 1'b1; mu_result = 32'h1234_0001;
    step();
    chk("fp_grant1", 32'(grant_id), 32'h1);
    chk("fp_mu_addr1", mu_addr, 32'h0000_0200);
    chk("fp_mu_wr1", 32'(mu_wr), 32'h1);
    chk("fp_mu_value1", mu_value, 32'h1111_1111);
    expect_done(3'b010, 32'h1234_0001);
    step();
    ch_valid = 3'b001; mu_result = 32'h1234_0002;
    chk("fp_bubble", 32'(busy), 32'h0);
    step();
    chk("fp_grant0", 32'(grant_id), 32'h0);
    chk("fp_mu_addr0", mu_addr, 32'h0000_0300);
    expect_done(3'b001, 32'h1234_0002);
    step();
    ch_valid = 3'b000; mu_ready = 1'b0;
    chk("fp_idle", 32'(busy), 32'h0);
`endif

    // Flush of channel 2 coincident with mu_ready. Channel 2 is flushable
    // in the default instance and not flushable in the masked one.
    set_ch(2, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
    ch_valid = 3'b100;
    step();
    chk("fl_grant", 32'(grant_id), 32'h2);
    chk("fl_m_grant", 32'(m_grant_id), 32'h2);
    flush_in = 1'b1; mu_ready = 1'b1; mu_result = 32'hCAFE_F00D;
    #1;
    chk("fl_no_ready", 32'(ch_ready), 32'h0);
    chk("fl_m_ready", 32'(m_ch_ready), 32'h4);
    chk("fl_m_result", m_ch_result, 32'hCAFE_F00D);
    step();
    ch_valid = 3'b000; flush_in = 1'b0; mu_ready = 1'b0;
    chk("fl_idle", 32'(busy), 32'h0);
    chk("fl_m_idle", 32'(m_busy), 32'h0);

    // A flush in IDLE suppresses arbitration for that cycle
    ch_valid = 3'b001; flush_in = 1'b1;
    step();
    chk("fl_idle_suppress", 32'(busy), 32'h0);
    flush_in = 1'b0;
    step();
    chk("fl_idle_then_grant", 32'(busy), 32'h1);
    mu_ready = 1'b1; mu_result = 32'h0BAD_0001;
    expect_done(3'b001, 32'h0BAD_0001);
    step();
    ch_valid = 3'b000; mu_ready = 1'b0;
    step();

    // Stall: rdy_in low for 5 cycles in BUSY with mu_ready high
    set_ch(1, 1'b0, 3'b000, 32'h0000_0500, 32'h0);
    ch_valid = 3'b010;
    step();
    chk("st_grant", 32'(grant_id), 32'h1);
    rdy_in = 1'b0; mu_ready = 1'b1; mu_result = 32'h5555_AAAA;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("st_no_ready", 32'(ch_ready), 32'h0);
      step();
      chk("st_grant_hold", 32'(grant_id), 32'h1);
      chk("st_busy_hold", 32'(busy), 32'h1);
    end
    rdy_in = 1'b1;
    expect_done(3'b010, 32'h5555_AAAA);
    step();
    ch_valid = 3'b000; mu_ready = 1'b0;
    chk("st_idle", 32'(busy), 32'h0);

    // Reset in the middle of a transaction
    ch_valid = 3'b100;
    step();
    chk("rm_mu_valid_pre", 32'(mu_valid), 32'h1);
    rst_in = 1'b0; mu_ready = 1'b1; mu_result = 32'h7777_7777;
    step();
    chk("rm_mu_valid", 32'(mu_valid), 32'h0);
    chk("rm_busy", 32'(busy), 32'h0);
    chk("rm_grant", 32'(grant_id), 32'h0);
    rst_in = 1'b1; ch_valid = 3'b000; mu_ready = 1'b0;
    step(); step();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
